ad_ip_jesd204_tpl_adc_capture: RTL and testbench
================================================

Name: ad_ip_jesd204_tpl_adc_capture

Overview:
Parametrised capture stage between the TPL ADC channel formatters and the DMA interface. Gates formatted samples with a sync-armed capture state machine (software arm, external sync edge, finite or infinite capture length) and applies a per-channel enable mask. Buffers accepted beats in a FIFO with real ready/valid back-pressure and a sticky overflow flag. Replaces the always-ready, single-shot sync handling of the previous core generation.

Parameters:
NUM_CHANNELS, 4, number of converter channels
DATA_PATH_WIDTH, 1, samples per channel per beat
BITS_PER_SAMPLE, 16, formatted sample width
DMA_DATA_WIDTH, NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE, beat width
FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH beats
CAPTURE_LEN_WIDTH, 32, width of capture length counter
EXT_SYNC_STAGES, 2, synchroniser flops on ext_sync (min 2)

Ports:
clk  in  1  core clock, all logic rising-edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  formatted beat valid (no back-pressure upstream)
in_data  in  DMA_DATA_WIDTH  formatted beat
ch_enable  in  NUM_CHANNELS  per-channel enable, sampled with each write
sync_mode  in  2  0 free-run, 1 one-shot ext sync, 2 continuous re-arm, 3 reserved (= 0)
ext_sync_falling  in  1  0 rising-edge trigger, 1 falling-edge trigger
arm  in  1  single-cycle arm request
disarm  in  1  single-cycle abort
ext_sync  in  1  asynchronous external sync
capture_len  in  CAPTURE_LEN_WIDTH  beats per capture, 0 = unlimited
overflow_clr  in  1  clears sticky overflow
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_data  out  DMA_DATA_WIDTH  FIFO head beat, disabled channels zeroed
out_ch_valid  out  NUM_CHANNELS  ch_enable captured with the head beat
status_armed  out  1  state == ARMED
status_capturing  out  1  state == CAPTURE
capture_done  out  1  one-cycle pulse at end of finite capture
overflow  out  1  sticky: beat dropped on full FIFO
fifo_level  out  FIFO_ADDR_WIDTH+1  occupancy
sync_timestamp  out  64  see Optional Feature

Behaviour:
- Reset: state IDLE; FIFO empty; all outputs 0.
- States: IDLE, ARMED, CAPTURE (2-bit encoding).
- IDLE: mode 0 -> CAPTURE next cycle; arm with mode 1/2 -> ARMED.
- ARMED: detected ext_sync edge -> CAPTURE.
- CAPTURE: write FIFO on each in_valid. Counter loads capture_len on entry and decrements per accepted in_valid.
- Capture end: at count 1 with in_valid -> capture_done pulse next cycle. Then mode 1 -> IDLE, mode 2 -> ARMED. capture_len=0 never ends.
- disarm in any state -> IDLE next cycle; no capture_done. Wins over simultaneous arm and over a simultaneous sync edge. arm in ARMED/CAPTURE ignored.
- Ext sync path: EXT_SYNC_STAGES sync flops, then one edge-detect flop. An edge at the pin reaches CAPTURE within EXT_SYNC_STAGES+2 cycles. First written beat = first in_valid while in CAPTURE.
- Mode change outside IDLE takes effect only on the next IDLE/ARMED decision.
- Write data: disabled channel lanes forced to 0 before storage; ch_enable stored alongside as out_ch_valid.
- FIFO: first-word-fall-through. Write in cycle N -> out_valid in N+1. Read on out_valid&&out_ready. Simultaneous read+write when full is allowed (no drop). Pointers wrap modulo depth; level uses an extra bit.
- Overflow: write while full and no read -> beat dropped, overflow set next cycle. Beat still counted toward capture_len. overflow_clr clears; a same-cycle set wins.
- rst mid-capture: flushes FIFO, drops in-flight beats.

Optional Feature:
ADC_CAPTURE_TIMESTAMP_EN
- Defined: 64-bit free-running counter, reset 0, increments on every in_valid, wraps. Value latched into sync_timestamp on each IDLE/ARMED -> CAPTURE transition.
- Undefined: counter absent; sync_timestamp tied to 0. Port list unchanged.

Decomposition:
- Package ad_ip_jesd204_tpl_adc_capture_pkg: state encoding, sync_mode constants (FREE_RUN, ONE_SHOT, CONTINUOUS), TIMESTAMP_WIDTH=64.
- Sub-module ad_ip_jesd204_tpl_adc_capture_fifo: FWFT FIFO with level and full/empty; parent owns overflow logic.

Test Plan:
- mode 0, capture_len=0, in_valid continuous, out_ready=1 -> CAPTURE 1 cycle after reset release; out_valid 1 cycle after each write; data matches bit-exact.
- mode 1, arm, rising ext_sync, capture_len=8 -> exactly 8 beats out, capture_done once, returns IDLE; later ext_sync edges ignored.
- mode 2, capture_len=4, three ext_sync pulses -> 12 beats, 3 capture_done pulses, status_armed between captures; falling-edge select ignores rising edges.
- ch_enable=4'b0101, incrementing data -> channels 1 and 3 zero in out_data; out_ch_valid=0101.
- out_ready=0, 20 beats, depth 16 -> fifo_level=16, overflow=1, 4 beats dropped, first 16 intact; overflow_clr clears; simultaneous read+write at full drops nothing.
- disarm with ext_sync edge on same cycle in ARMED -> IDLE, no capture; with ADC_CAPTURE_TIMESTAMP_EN, sync_timestamp equals in_valid count at CAPTURE entry (e.g. 37).

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_capture_pkg.sv
// Shared encodings for the TPL ADC capture stage: FSM states, sync modes
// and the timestamp width.
package ad_ip_jesd204_tpl_adc_capture_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   localparam logic [1:0] FREE_RUN   = 2'd0;
   localparam logic [1:0] ONE_SHOT   = 2'd1;
   localparam logic [1:0] CONTINUOUS = 2'd2;

   localparam int TIMESTAMP_WIDTH = 64;

   // Reserved mode 3 behaves like free-run, so only 1 and 2 wait for sync.
   function automatic logic is_sync_mode(input logic [1:0] mode);
      return (mode == ONE_SHOT) || (mode == CONTINUOUS);
   endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_fifo.sv
// First-word-fall-through FIFO with occupancy level; the parent decides
// whether a write is accepted and tracks overflow.
module ad_ip_jesd204_tpl_adc_capture_fifo #(
   parameter int DATA_WIDTH = 68,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   level_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [ADDR_WIDTH:0]   wr_ptr_q;
   logic [ADDR_WIDTH:0]   rd_ptr_q;

   // NOTE: the storage array has no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign level_o   = wr_ptr_q - rd_ptr_q;
   assign empty_o   = (level_o == '0);
   assign full_o    = level_o[ADDR_WIDTH];
   assign rd_data_o = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// Sync-armed capture gate, channel mask and FWFT buffer between the TPL ADC
// formatters and the DMA. Define ADC_CAPTURE_TIMESTAMP_EN for sync_timestamp.
module ad_ip_jesd204_tpl_adc_capture
   import ad_ip_jesd204_tpl_adc_capture_pkg::*;
#(
   parameter int NUM_CHANNELS      = 4,
   parameter int DATA_PATH_WIDTH   = 1,
   parameter int BITS_PER_SAMPLE   = 16,
   parameter int DMA_DATA_WIDTH    = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE,
   parameter int FIFO_ADDR_WIDTH   = 4,
   parameter int CAPTURE_LEN_WIDTH = 32,
   parameter int EXT_SYNC_STAGES   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [DMA_DATA_WIDTH-1:0]    in_data,
   input  logic [NUM_CHANNELS-1:0]      ch_enable,
   input  logic [1:0]                   sync_mode,
   input  logic                         ext_sync_falling,
   input  logic                         arm,
   input  logic                         disarm,
   input  logic                         ext_sync,
   input  logic [CAPTURE_LEN_WIDTH-1:0] capture_len,
   input  logic                         overflow_clr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DMA_DATA_WIDTH-1:0]    out_data,
   output logic [NUM_CHANNELS-1:0]      out_ch_valid,
   output logic                         status_armed,
   output logic                         status_capturing,
   output logic                         capture_done,
   output logic                         overflow,
   output logic [FIFO_ADDR_WIDTH:0]     fifo_level,
   output logic [TIMESTAMP_WIDTH-1:0]   sync_timestamp
);

   localparam int LANE_W = DATA_PATH_WIDTH * BITS_PER_SAMPLE;
   localparam int FIFO_W = DMA_DATA_WIDTH + NUM_CHANNELS;

   logic [1:0]                   state_q, state_d;
   logic [CAPTURE_LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic                         done_q, done_d;
   logic                         overflow_q;
   logic [EXT_SYNC_STAGES-1:0]   sync_q;
   logic                         sync_prev_q;
   logic                         sync_edge;
   logic                         capture_enter;

   logic                         wr_req, wr_en, rd_en, ovf_set;
   logic [DMA_DATA_WIDTH-1:0]    masked_data;
   logic [FIFO_W-1:0]            fifo_rd_data;
   logic                         fifo_empty, fifo_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[EXT_SYNC_STAGES-2:0], ext_sync};
         sync_prev_q <= sync_q[EXT_SYNC_STAGES-1];
      end
   end

   assign sync_edge = ext_sync_falling ? (~sync_q[EXT_SYNC_STAGES-1] &  sync_prev_q)
                                       : ( sync_q[EXT_SYNC_STAGES-1] & ~sync_prev_q);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!is_sync_mode(sync_mode)) state_d = ST_CAPTURE;
            else if (arm)                 state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (sync_edge) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // A zero count means unlimited capture and is never decremented.
            if (in_valid && (cnt_q != '0)) begin
               if (cnt_q == CAPTURE_LEN_WIDTH'(1)) begin
                  done_d  = 1'b1;
                  state_d = (sync_mode == CONTINUOUS) ? ST_ARMED : ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CAPTURE_LEN_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (disarm) begin
         state_d = ST_IDLE;
         done_d  = 1'b0;
      end
      if (capture_enter) cnt_d = capture_len;
   end

   assign capture_enter = (state_q != ST_CAPTURE) && (state_d == ST_CAPTURE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (ovf_set)           overflow_q <= 1'b1;
         else if (overflow_clr) overflow_q <= 1'b0;
      end
   end

   always_comb begin
      masked_data = in_data;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (!ch_enable[c]) masked_data[c*LANE_W +: LANE_W] = '0;
      end
   end

   // A read frees a slot in the same cycle, so full plus read still accepts.
   assign wr_req  = (state_q == ST_CAPTURE) && in_valid;
   assign rd_en   = out_valid && out_ready;
   assign wr_en   = wr_req && (!fifo_full || rd_en);
   assign ovf_set = wr_req && fifo_full && !rd_en;

   ad_ip_jesd204_tpl_adc_capture_fifo #(
      .DATA_WIDTH (FIFO_W),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i ({ch_enable, masked_data}),
      .rd_en_i   (rd_en),
      .rd_data_o (fifo_rd_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full),
      .level_o   (fifo_level)
   );

   assign out_valid        = !fifo_empty;
   assign out_data         = out_valid ? fifo_rd_data[DMA_DATA_WIDTH-1:0] : '0;
   assign out_ch_valid     = out_valid ? fifo_rd_data[FIFO_W-1:DMA_DATA_WIDTH] : '0;
   assign status_armed     = (state_q == ST_ARMED);
   assign status_capturing = (state_q == ST_CAPTURE);
   assign capture_done     = done_q;
   assign overflow         = overflow_q;

`ifdef ADC_CAPTURE_TIMESTAMP_EN
   logic [TIMESTAMP_WIDTH-1:0] ts_cnt_q;
   logic [TIMESTAMP_WIDTH-1:0] ts_latch_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_cnt_q   <= '0;
         ts_latch_q <= '0;
      end else begin
         if (in_valid)      ts_cnt_q   <= ts_cnt_q + 1'b1;
         if (capture_enter) ts_latch_q <= ts_cnt_q;
      end
   end

   assign sync_timestamp = ts_latch_q;
`else
   assign sync_timestamp = '0;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture.sv
// Directed bench for the TPL ADC capture stage: free-run, one-shot and
// continuous sync capture, channel masking, overflow and disarm priority.
module tb_ad_ip_jesd204_tpl_adc_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_data;
   logic [3:0]  ch_enable;
   logic [1:0]  sync_mode;
   logic        ext_sync_falling;
   logic        arm;
   logic        disarm;
   logic        ext_sync;
   logic [31:0] capture_len;
   logic        overflow_clr;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [3:0]  out_ch_valid;
   logic        status_armed;
   logic        status_capturing;
   logic        capture_done;
   logic        overflow;
   logic [4:0]  fifo_level;
   logic [63:0] sync_timestamp;

   int          checks = 0;
   int          errors = 0;
   int          seq = 0;
   int          out_cnt = 0;
   int          done_cnt = 0;
   int          n;
   logic [63:0] exp_q [$];
   logic [3:0]  exp_ch;
   longint      iv_cnt;
   longint      ts_exp;

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst)           iv_cnt <= 0;
      else if (in_valid) iv_cnt <= iv_cnt + 1;
   end

   ad_ip_jesd204_tpl_adc_capture dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .ch_enable        (ch_enable),
      .sync_mode        (sync_mode),
      .ext_sync_falling (ext_sync_falling),
      .arm              (arm),
      .disarm           (disarm),
      .ext_sync         (ext_sync),
      .capture_len      (capture_len),
      .overflow_clr     (overflow_clr),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_ch_valid     (out_ch_valid),
      .status_armed     (status_armed),
      .status_capturing (status_capturing),
      .capture_done     (capture_done),
      .overflow         (overflow),
      .fifo_level       (fifo_level),
      .sync_timestamp   (sync_timestamp)
   );

   // Channel c of beat k carries 16'h{c}000 + k.
   function automatic logic [63:0] pat(input int k);
      logic [15:0] kk;
      kk = k[15:0];
      return {16'h3000 + kk, 16'h2000 + kk, 16'h1000 + kk, 16'h0000 + kk};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: drive in_valid, score the beat the coming edge will consume.
   task automatic cycle(input logic iv);
      in_valid = iv;
      if (iv) begin
         in_data = pat(seq);
         seq++;
      end else begin
         in_data = '0;
      end
      if (out_valid && out_ready) begin
         out_cnt++;
         if (exp_q.size() == 0) begin
            check("extra_beat", {63'd0, out_valid}, 64'd0);
         end else begin
            check("beat_data", out_data, exp_q.pop_front());
            check("beat_ch", {60'd0, out_ch_valid}, {60'd0, exp_ch});
         end
      end
      if (capture_done) done_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_capture(input int max_cycles, output int waited);
      waited = 0;
      while (!status_capturing && waited < max_cycles) begin
         cycle(1'b0);
         waited++;
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      ch_enable = 4'hF;
      exp_ch = 4'hF;
      sync_mode = 2'd0;
      ext_sync_falling = 1'b0;
      arm = 1'b0;
      disarm = 1'b0;
      ext_sync = 1'b0;
      capture_len = 32'd0;
      overflow_clr = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      check("rst_armed", {63'd0, status_armed}, 64'd0);
      check("rst_capturing", {63'd0, status_capturing}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_level", {59'd0, fifo_level}, 64'd0);
      check("rst_overflow", {63'd0, overflow}, 64'd0);
      check("rst_done", {63'd0, capture_done}, 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_timestamp", sync_timestamp, 64'd0);

      // Free-run, unlimited length.
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("t1_entry", {63'd0, status_capturing}, 64'd1);
      for (int i = 0; i < 4; i++) exp_q.push_back(pat(seq + i));
      cycle(1'b1);
      check("t1_valid_next", {63'd0, out_valid}, 64'd1);
      check("t1_level", {59'd0, fifo_level}, 64'd1);
      repeat (3) cycle(1'b1);
      repeat (2) cycle(1'b0);
      check("t1_count", 64'(out_cnt), 64'd4);
      check("t1_empty", {63'd0, out_valid}, 64'd0);
      sync_mode = 2'd1;
      disarm = 1'b1;
      cycle(1'b0);
      disarm = 1'b0;
      check("t1_disarmed", {62'd0, status_armed, status_capturing}, 64'd0);

      // One-shot, 8 beats on rising ext_sync.
      capture_len = 32'd8;
      arm = 1'b1;
      cycle(1'b0);
      arm = 1'b0;
      check("t2_armed", {63'd0, status_armed}, 64'd1);
      ts_exp = iv_cnt;
      ext_sync = 1'b1;
      wait_capture(6, n);
      check("t2_capturing", {63'd0, status_capturing}, 64'd1);
      check("t2_latency", {63'd0, (n <= 4)}, 64'd1);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
      check("t2_timestamp", sync_timestamp, 64'(ts_exp));
`else
      check("t2_timestamp", sync_timestamp, 64'd0);
`endif
      out_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) exp_q.push_back(pat(seq + i));
      repeat (10) cycle(1'b1);
      repeat (3) cycle(1'b0);
      check("t2_beats", 64'(out_cnt), 64'd8);
      check("t2_done", 64'(done_cnt), 64'd1);
      check("t2_idle", {62'd0, status_armed, status_capturing}, 64'd0);
      ext_sync = 1'b0;
      repeat (4) cycle(1'b0);
      ext_sync = 1'b1;
      repeat (6) cycle(1'b1);
      check("t2_late_sync", {62'd0, status_armed, status_capturing}, 64'd0);
      check("t2_late_level", {59'd0, fifo_level}, 64'd0);

      // Continuous re-arm, 3 captures of 4 beats.
      sync_mode = 2'd2;
      capture_len = 32'd4;
      ext_sync = 1'b0;
      repeat (4) cycle(1'b0);
      arm = 1'b1;
      cycle(1'b0);
      arm = 1'b0;
      out_cnt = 0;
      done_cnt = 0;
      for (int p = 0; p < 3; p++) begin
         ext_sync = 1'b1;
         wait_capture(6, n);
         check("t3_capturing", {63'd0, status_capturing}, 64'd1);
         ext_sync = 1'b0;
         for (int i = 0; i < 4; i++) exp_q.push_back(pat(seq + i));
         repeat (6) cycle(1'b1);
         repeat (2) cycle(1'b0);
         check("t3_rearmed", {63'd0, status_armed}, 64'd1);
      end
      check("t3_beats", 64'(out_cnt), 64'd12);
      check("t3_done", 64'(done_cnt), 64'd3);
      ext_sync_falling = 1'b1;
      ext_sync = 1'b1;
      repeat (6) cycle(1'b0);
      check("t3_rise_ignored", {62'd0, status_armed, status_capturing}, 64'd2);
      ext_sync = 1'b0;
      wait_capture(6, n);
      check("t3_fall_capture", {63'd0, status_capturing}, 64'd1);
      disarm = 1'b1;
      cycle(1'b0);
      disarm = 1'b0;
      check("t3_disarm", {62'd0, status_armed, status_capturing}, 64'd0);
      check("t3_no_done", 64'(done_cnt), 64'd3);

      // Channel mask 0101.
      ext_sync_falling = 1'b0;
      ch_enable = 4'b0101;
      exp_ch = 4'b0101;
      capture_len = 32'd0;
      sync_mode = 2'd0;
      cycle(1'b0);
      check("t4_capturing", {63'd0, status_capturing}, 64'd1);
      out_cnt = 0;
      for (int i = 0; i < 3; i++) exp_q.push_back(pat(seq + i) & 64'h0000_FFFF_0000_FFFF);
      repeat (3) cycle(1'b1);
      repeat (2) cycle(1'b0);
      check("t4_beats", 64'(out_cnt), 64'd3);
      sync_mode = 2'd1;
      disarm = 1'b1;
      cycle(1'b0);
      disarm = 1'b0;

      // Overflow with a stalled consumer.
      ch_enable = 4'hF;
      exp_ch = 4'hF;
      out_ready = 1'b0;
      sync_mode = 2'd0;
      cycle(1'b0);
      out_cnt = 0;
      for (int i = 0; i < 16; i++) exp_q.push_back(pat(seq + i));
      repeat (20) cycle(1'b1);
      check("t5_level_full", {59'd0, fifo_level}, 64'd16);
      check("t5_overflow", {63'd0, overflow}, 64'd1);
      overflow_clr = 1'b1;
      cycle(1'b1);
      overflow_clr = 1'b0;
      check("t5_set_wins", {63'd0, overflow}, 64'd1);
      overflow_clr = 1'b1;
      cycle(1'b0);
      overflow_clr = 1'b0;
      check("t5_cleared", {63'd0, overflow}, 64'd0);
      out_ready = 1'b1;
      exp_q.push_back(pat(seq));
      cycle(1'b1);
      check("t5_rw_level", {59'd0, fifo_level}, 64'd16);
      check("t5_rw_no_drop", {63'd0, overflow}, 64'd0);
      repeat (17) cycle(1'b0);
      check("t5_drained", 64'(out_cnt), 64'd17);
      check("t5_level_empty", {59'd0, fifo_level}, 64'd0);
      sync_mode = 2'd1;
      disarm = 1'b1;
      cycle(1'b0);
      disarm = 1'b0;

      // Disarm priority over arm and over a coincident sync edge.
      capture_len = 32'd8;
      arm = 1'b1;
      disarm = 1'b1;
      cycle(1'b0);
      arm = 1'b0;
      disarm = 1'b0;
      check("t6_arm_vs_disarm", {63'd0, status_armed}, 64'd0);
      arm = 1'b1;
      cycle(1'b0);
      arm = 1'b0;
      check("t6_armed", {63'd0, status_armed}, 64'd1);
      ext_sync = 1'b1;
      cycle(1'b0);
      cycle(1'b0);
      disarm = 1'b1;
      cycle(1'b0);
      disarm = 1'b0;
      check("t6_edge_vs_disarm", {62'd0, status_armed, status_capturing}, 64'd0);
      out_cnt = 0;
      repeat (4) cycle(1'b1);
      check("t6_no_capture", {62'd0, status_armed, status_capturing}, 64'd0);
      check("t6_no_beats", {59'd0, fifo_level}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
